mem_port_arbiter: RTL and testbench

- Shares the single unified instruction/data memory between two requesters.
- Requester 0 is the multicycle ARM core port. Requester 1 is a debug/display scanner that reads words for the hex display.
- Round-robin arbitration, with bounded ownership bursts via a per-requester lock.
- One memory transaction per cycle. Writes commit at the clock edge; read data is returned registered, one cycle later.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_arb_rr2_pick.sv | 33 +++
 rtl/mem_port_arbiter.sv | 167 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared encodings and defaults for the two-port memory arbiter.
// Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    localparam int REQ_CPU      = 0;
    localparam int REQ_DBG      = 1;
    localparam int MAX_HOLD_DEF = 4;

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_arb_rr2_pick.sv
// ============================================================================
// Module      : arb_rr2_pick
// Description : Combinational two-way round-robin pick with lock retention.
// Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module arb_rr2_pick (
    input  logic [1:0] req_i,
    input  logic [1:0] own_i,
    input  logic [1:0] lock_i,
    input  logic       last_i,
    input  logic       hold_lim_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        // A locking owner keeps the port unless the peer has waited out the hold budget.
        if (own_i[0] && lock_i[0] && req_i[0] && (!req_i[1] || !hold_lim_i)) begin
            gnt_o = 2'b01;
        end else if (own_i[1] && lock_i[1] && req_i[1] && (!req_i[0] || !hold_lim_i)) begin
            gnt_o = 2'b10;
        end else if (req_i == 2'b11) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else begin
            gnt_o = req_i;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one unified memory between the CPU port and the debug
//               scanner. Optional grant/conflict counters: ARB_PERF_CNT_EN.
// Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic          r0_lock,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic          r1_lock,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
`ifdef ARB_PERF_CNT_EN
    ,
    output logic [31:0]   perf_gnt0,
    output logic [31:0]   perf_gnt1,
    output logic [31:0]   perf_conflict
`endif
);

    localparam logic [3:0] c_max_hold = 4'(MAX_HOLD);

    arb_state_e state_q, state_d;
    logic       last_q, last_d;
    logic [3:0] hold_q, hold_d;
    logic [3:0] w_hold_inc;

    logic [1:0] w_req;
    logic [1:0] w_own;
    logic [1:0] w_lock;
    logic [1:0] w_pick;
    logic [1:0] w_gnt;
    logic       w_hold_lim;

    logic          rvalid0_q, rvalid1_q;
    logic [DW-1:0] rdata0_q,  rdata1_q;

    assign w_req      = {r1_req, r0_req};
    assign w_lock     = {r1_lock, r0_lock};
    assign w_own      = {state_q == OWN1, state_q == OWN0};
    assign w_hold_lim = (hold_q >= c_max_hold);
    assign w_hold_inc = (hold_q == 4'hF) ? hold_q : hold_q + 4'd1;

    arb_rr2_pick u_pick (
        .req_i      (w_req),
        .own_i      (w_own),
        .lock_i     (w_lock),
        .last_i     (last_q),
        .hold_lim_i (w_hold_lim),
        .gnt_o      (w_pick)
    );

    assign w_gnt  = reset ? 2'b00 : w_pick;
    assign r0_gnt = w_gnt[REQ_CPU];
    assign r1_gnt = w_gnt[REQ_DBG];

    always_comb begin
        mem_we = 1'b0;
        mem_a  = '0;
        mem_wd = '0;
        if (w_gnt[REQ_CPU]) begin
            mem_we = r0_we;
            mem_a  = r0_addr;
            mem_wd = r0_wdata;
        end else if (w_gnt[REQ_DBG]) begin
            mem_we = r1_we;
            mem_a  = r1_addr;
            mem_wd = r1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            hold_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

    // hold only grows while the same owner keeps winning against a waiting peer.
    always_comb begin
        state_d = IDLE;
        last_d  = last_q;
        hold_d  = 4'd0;
        if (w_gnt[REQ_CPU]) begin
            last_d = 1'b0;
            if (r0_lock) state_d = OWN0;
            if (!last_q && r1_req) hold_d = w_hold_inc;
        end else if (w_gnt[REQ_DBG]) begin
            last_d = 1'b1;
            if (r1_lock) state_d = OWN1;
            if (last_q && r0_req) hold_d = w_hold_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= w_gnt[REQ_CPU] & ~r0_we;
            rvalid1_q <= w_gnt[REQ_DBG] & ~r1_we;
            if (w_gnt[REQ_CPU] && !r0_we) rdata0_q <= mem_rd;
            if (w_gnt[REQ_DBG] && !r1_we) rdata1_q <= mem_rd;
        end
    end

    // A read still in flight when reset arrives must not be reported.
    assign r0_rvalid = rvalid0_q & ~reset;
    assign r1_rvalid = rvalid1_q & ~reset;
    assign r0_rdata  = rdata0_q;
    assign r1_rdata  = rdata1_q;

`ifdef ARB_PERF_CNT_EN
    logic [31:0] gnt0_cnt_q, gnt1_cnt_q, conf_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt0_cnt_q <= 32'd0;
            gnt1_cnt_q <= 32'd0;
            conf_cnt_q <= 32'd0;
        end else begin
            if (w_gnt[REQ_CPU])    gnt0_cnt_q <= gnt0_cnt_q + 32'd1;
            if (w_gnt[REQ_DBG])    gnt1_cnt_q <= gnt1_cnt_q + 32'd1;
            if (r0_req && r1_req)  conf_cnt_q <= conf_cnt_q + 32'd1;
        end
    end

    assign perf_gnt0     = gnt0_cnt_q;
    assign perf_gnt1     = gnt1_cnt_q;
    assign perf_conflict = conf_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed vector bench for mem_port_arbiter.
// Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int   AW = 32;
    localparam int   DW = 32;
    localparam logic N  = 1'b0;
    localparam logic Y  = 1'b1;

    logic          clk = 1'b0;
    logic          reset;
    logic          r0_req, r0_we, r0_lock, r0_gnt, r0_rvalid;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata, r0_rdata;
    logic          r1_req, r1_we, r1_lock, r1_gnt, r1_rvalid;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata, r1_rdata;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [DW-1:0] mem_wd, mem_rd;
`ifdef ARB_PERF_CNT_EN
    logic [31:0]   perf_gnt0, perf_gnt1, perf_conflict;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset),
        .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
        .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
        .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
`ifdef ARB_PERF_CNT_EN
        , .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_conflict(perf_conflict)
`endif
    );

    typedef struct {
        logic        rst, q0, we0, lk0;
        logic [31:0] a0, d0;
        logic        q1, we1, lk1;
        logic [31:0] a1, d1, rd;
        logic        g0, g1, mwe;
        logic [31:0] ma, mwd;
        logic        v0;
        logic [31:0] rd0;
        logic        v1;
        logic [31:0] rd1;
        logic        ck;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic rst, q0, we0, lk0, input logic [31:0] a0, d0,
        input logic q1, we1, lk1, input logic [31:0] a1, d1, rd,
        input logic g0, g1, mwe, input logic [31:0] ma, mwd,
        input logic v0, input logic [31:0] rd0, input logic v1, input logic [31:0] rd1,
        input logic ck);
        vec_t v;
        v.rst = rst; v.q0 = q0; v.we0 = we0; v.lk0 = lk0; v.a0 = a0; v.d0 = d0;
        v.q1 = q1; v.we1 = we1; v.lk1 = lk1; v.a1 = a1; v.d1 = d1; v.rd = rd;
        v.g0 = g0; v.g1 = g1; v.mwe = mwe; v.ma = ma; v.mwd = mwd;
        v.v0 = v0; v.rd0 = rd0; v.v1 = v1; v.rd1 = rd1; v.ck = ck;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset = v.rst;
        r0_req = v.q0; r0_we = v.we0; r0_lock = v.lk0; r0_addr = v.a0; r0_wdata = v.d0;
        r1_req = v.q1; r1_we = v.we1; r1_lock = v.lk1; r1_addr = v.a1; r1_wdata = v.d1;
        mem_rd = v.rd;
    endtask

    task automatic idle_inputs();
        r0_req = N; r0_we = N; r0_lock = N; r0_addr = 32'h0; r0_wdata = 32'h0;
        r1_req = N; r1_we = N; r1_lock = N; r1_addr = 32'h0; r1_wdata = 32'h0;
        mem_rd = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  cnt;
        bit  done;

        // rst q0 we0 lk0 a0 d0 | q1 we1 lk1 a1 d1 | rd || g0 g1 mwe ma mwd | v0 rd0 v1 rd1 ck
        vq.push_back(mk(Y,Y,N,N,32'h0,32'h0, N,N,N,32'h0,32'h0, 32'h0,
                        N,N,N,32'h0,32'h0, N,32'h0,N,32'h0,Y));
        vq.push_back(mk(N,Y,N,N,32'h10,32'h0, N,N,N,32'h0,32'h0, 32'hDEADBEEF,
                        Y,N,N,32'h10,32'h0, N,32'h0,N,32'h0,Y));
        vq.push_back(mk(N,N,N,N,32'h0,32'h0, N,N,N,32'h0,32'h0, 32'h0,
                        N,N,N,32'h0,32'h0, Y,32'hDEADBEEF,N,32'h0,Y));
        vq.push_back(mk(N,N,N,N,32'h0,32'h0, Y,N,N,32'h40,32'h0, 32'hCAFE0001,
                        N,Y,N,32'h40,32'h0, N,32'hDEADBEEF,N,32'h0,Y));
        vq.push_back(mk(N,Y,N,N,32'h100,32'h0, Y,N,N,32'h200,32'h0, 32'hA0,
                        Y,N,N,32'h100,32'h0, N,32'hDEADBEEF,Y,32'hCAFE0001,Y));
        vq.push_back(mk(N,Y,N,N,32'h100,32'h0, Y,N,N,32'h200,32'h0, 32'hA1,
                        N,Y,N,32'h200,32'h0, Y,32'hA0,N,32'hCAFE0001,Y));
        vq.push_back(mk(N,Y,N,N,32'h104,32'h0, Y,N,N,32'h200,32'h0, 32'hA2,
                        Y,N,N,32'h104,32'h0, N,32'hA0,Y,32'hA1,Y));
        vq.push_back(mk(N,Y,N,N,32'h104,32'h0, Y,N,N,32'h204,32'h0, 32'hA3,
                        N,Y,N,32'h204,32'h0, Y,32'hA2,N,32'hA1,Y));
        vq.push_back(mk(N,Y,Y,N,32'h20,32'h55, N,N,N,32'h0,32'h0, 32'hFFFFFFFF,
                        Y,N,Y,32'h20,32'h55, N,32'hA2,Y,32'hA3,Y));
        vq.push_back(mk(N,N,N,N,32'h0,32'h0, N,N,N,32'h0,32'h0, 32'h0,
                        N,N,N,32'h0,32'h0, N,32'hA2,N,32'hA3,Y));
        vq.push_back(mk(N,N,N,N,32'h0,32'h0, Y,Y,N,32'h30,32'h77, 32'h0,
                        N,Y,Y,32'h30,32'h77, N,32'hA2,N,32'hA3,Y));
        // r0 locks against a waiting r1: five r0 grants, then forced hand-over.
        vq.push_back(mk(N,Y,N,Y,32'h300,32'h0, Y,N,N,32'h400,32'h0, 32'hB0,
                        Y,N,N,32'h300,32'h0, N,32'hA2,N,32'hA3,Y));
        vq.push_back(mk(N,Y,N,Y,32'h300,32'h0, Y,N,N,32'h400,32'h0, 32'hB1,
                        Y,N,N,32'h300,32'h0, Y,32'hB0,N,32'hA3,Y));
        vq.push_back(mk(N,Y,N,Y,32'h300,32'h0, Y,N,N,32'h400,32'h0, 32'hB2,
                        Y,N,N,32'h300,32'h0, Y,32'hB1,N,32'hA3,Y));
        vq.push_back(mk(N,Y,N,Y,32'h300,32'h0, Y,N,N,32'h400,32'h0, 32'hB3,
                        Y,N,N,32'h300,32'h0, Y,32'hB2,N,32'hA3,Y));
        vq.push_back(mk(N,Y,N,Y,32'h300,32'h0, Y,N,N,32'h400,32'h0, 32'hB4,
                        Y,N,N,32'h300,32'h0, Y,32'hB3,N,32'hA3,Y));
        vq.push_back(mk(N,Y,N,Y,32'h300,32'h0, Y,N,N,32'h400,32'h0, 32'hB5,
                        N,Y,N,32'h400,32'h0, Y,32'hB4,N,32'hA3,Y));
        vq.push_back(mk(N,Y,N,N,32'h300,32'h0, Y,N,N,32'h400,32'h0, 32'hB6,
                        Y,N,N,32'h300,32'h0, N,32'hB4,Y,32'hB5,Y));
        // Lock with req low releases ownership immediately.
        vq.push_back(mk(N,Y,N,Y,32'h300,32'h0, N,N,N,32'h0,32'h0, 32'hC0,
                        Y,N,N,32'h300,32'h0, Y,32'hB6,N,32'hB5,Y));
        vq.push_back(mk(N,N,N,Y,32'h0,32'h0, Y,N,N,32'h500,32'h0, 32'hC1,
                        N,Y,N,32'h500,32'h0, Y,32'hC0,N,32'hB5,Y));
        // Reset right after a granted r1 read.
        vq.push_back(mk(N,N,N,N,32'h0,32'h0, Y,N,Y,32'h600,32'h0, 32'hD0,
                        N,Y,N,32'h600,32'h0, N,32'hC0,Y,32'hC1,Y));
        vq.push_back(mk(Y,Y,N,N,32'h700,32'h0, Y,N,Y,32'h800,32'h0, 32'hD1,
                        N,N,N,32'h0,32'h0, N,32'hC0,N,32'hD0,N));
        vq.push_back(mk(N,Y,N,N,32'h700,32'h0, Y,N,Y,32'h800,32'h0, 32'hE0,
                        Y,N,N,32'h700,32'h0, N,32'h0,N,32'h0,Y));
        vq.push_back(mk(N,N,N,N,32'h0,32'h0, N,N,N,32'h0,32'h0, 32'h0,
                        N,N,N,32'h0,32'h0, Y,32'hE0,N,32'h0,Y));

        reset = Y;
        idle_inputs();
        repeat (2) @(posedge clk);

        foreach (vq[i]) begin
            tick();
            drive(vq[i]);
            @(negedge clk);
            chk($sformatf("v%0d r0_gnt", i), {31'h0, r0_gnt}, {31'h0, vq[i].g0});
            chk($sformatf("v%0d r1_gnt", i), {31'h0, r1_gnt}, {31'h0, vq[i].g1});
            chk($sformatf("v%0d mem_we", i), {31'h0, mem_we}, {31'h0, vq[i].mwe});
            chk($sformatf("v%0d mem_a", i), mem_a, vq[i].ma);
            if (vq[i].mwe) chk($sformatf("v%0d mem_wd", i), mem_wd, vq[i].mwd);
            chk($sformatf("v%0d r0_rvalid", i), {31'h0, r0_rvalid}, {31'h0, vq[i].v0});
            chk($sformatf("v%0d r1_rvalid", i), {31'h0, r1_rvalid}, {31'h0, vq[i].v1});
            if (vq[i].ck) begin
                chk($sformatf("v%0d r0_rdata", i), r0_rdata, vq[i].rd0);
                chk($sformatf("v%0d r1_rdata", i), r1_rdata, vq[i].rd1);
            end
        end

        // Bounded wait for the forced hand-over from a locking r0.
        tick();
        reset = Y;
        idle_inputs();
        tick();
        reset = N;
        r0_req = Y; r0_lock = Y; r0_addr = 32'h900;
        r1_req = Y; r1_addr = 32'hA00;
        cnt  = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            chk("burst onehot", {31'h0, r0_gnt & r1_gnt}, 32'h0);
            if (r1_gnt) done = 1'b1;
            else if (r0_gnt) cnt++;
            tick();
        end
        chk("burst r1 granted", {31'h0, done}, 32'h1);
        chk("burst r0 grants", cnt, 32'd5);
        r0_lock = N;
        @(negedge clk);
        chk("post burst r0_gnt", {31'h0, r0_gnt}, 32'h1);
        chk("post burst r1_gnt", {31'h0, r1_gnt}, 32'h0);

`ifdef ARB_PERF_CNT_EN
        tick();
        reset = Y;
        idle_inputs();
        tick();
        reset = N;
        @(negedge clk);
        chk("perf reset conflict", perf_conflict, 32'd0);
        r0_req = Y; r1_req = Y;
        repeat (6) tick();
        idle_inputs();
        @(negedge clk);
        chk("perf_conflict", perf_conflict, 32'd6);
        chk("perf_gnt0", perf_gnt0, 32'd3);
        chk("perf_gnt1", perf_gnt1, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
